// File: rtl/qea_run_sequencer.sv
// qea_run_sequencer: host-side sequencer for one QEA run. It accepts a command,
// streams gate-context words into the context RAM, initialises the state RAM to
// a basis state, pulses start and times the run (with an optional timeout), and
// can stream the final state vector out afterwards.
//   command : i_cmd_* with i_cmd_valid/o_cmd_ready, i_timeout_limit (0 = none)
//   context : i_ctx_valid/o_ctx_ready/i_ctx_data -> o_ctx_en/wea/addr/data
//   state   : o_state_ena/wea/addra/dina, i_qea_state_dout
//   core    : o_qea_start, o_qea_qbit_num, i_qea_complete
//   readback: o_rd_valid/i_rd_ready/o_rd_data/o_rd_last
//   status  : o_busy, o_done, o_timeout, o_cmd_error, o_exec_cycles
module qea_run_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int PE_NUM_WIDTH            = 2,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LATENCY              = 1,
    parameter int CYC_WIDTH               = 48
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_cmd_valid,
    output logic                                       o_cmd_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]                  i_cmd_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]         i_cmd_ins_num,
    input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0]   i_cmd_init_idx,
    input  logic                                       i_cmd_readback,
    input  logic [31:0]                                i_timeout_limit,
    input  logic                                       i_ctx_valid,
    output logic                                       o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]         i_ctx_data,
    output logic                                       o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]                  o_qea_qbit_num,
    output logic                                       o_ctx_en,
    output logic                                       o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]         o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]         o_ctx_data,
    output logic                                       o_state_ena,
    output logic                                       o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]                o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]         o_state_dina,
    input  logic                                       i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]         i_qea_state_dout,
    output logic                                       o_rd_valid,
    input  logic                                       i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]         o_rd_data,
    output logic                                       o_rd_last,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic                                       o_timeout,
    output logic                                       o_cmd_error,
    output logic [CYC_WIDTH-1:0]                       o_exec_cycles
);
    localparam int IW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam logic [MAX_QBIT_WIDTH-1:0] Q_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] Q_MAX = MAX_QBIT_WIDTH'(IW);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] CA_ONE = GATE_CONTEXT_ADDR_WIDTH'(1);
    localparam logic [STATE_ADDR_WIDTH-1:0] RA_ONE = STATE_ADDR_WIDTH'(1);
    localparam logic [CYC_WIDTH-1:0] CY_ONE = CYC_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] RE_ONE = DATA_WIDTH'(1) << NUM_FRAC_BIT;
    localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE = {RE_ONE, {DATA_WIDTH{1'b0}}};

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_INIT     = 4'd2;
    localparam logic [3:0] S_START    = 4'd3;
    localparam logic [3:0] S_RUN      = 4'd4;
    localparam logic [3:0] S_RB_ISSUE = 4'd5;
    localparam logic [3:0] S_RB_WAIT  = 4'd6;
    localparam logic [3:0] S_RB_HOLD  = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]                         state;
    logic [MAX_QBIT_WIDTH-1:0]          qbit;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr;
    logic [IW-1:0]                      init_idx;
    logic [STATE_ADDR_WIDTH-1:0]        row;
    logic [STATE_ADDR_WIDTH-1:0]        last_row;
    logic                               readback;
    logic [31:0]                        limit;
    logic [CYC_WIDTH-1:0]               cyc;
    logic [31:0]                        wait_cnt;
    logic                               cmd_ok;
    logic [MAX_QBIT_WIDTH-1:0]          shamt;

    assign cmd_ok = i_cmd_qbit_num >= Q_MIN && i_cmd_qbit_num <= Q_MAX;
    // Right-shifting an all-ones word by (IW - qbit) yields both the index
    // mask and, on the row-address slice, the last row index ROWS-1.
    assign shamt = Q_MAX - i_cmd_qbit_num;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            qbit          <= '0;
            ins_num       <= '0;
            ctx_addr      <= '0;
            init_idx      <= '0;
            row           <= '0;
            last_row      <= '0;
            readback      <= 1'b0;
            limit         <= '0;
            cyc           <= '0;
            wait_cnt      <= '0;
            o_exec_cycles <= '0;
            o_timeout     <= 1'b0;
            o_cmd_error   <= 1'b0;
            o_rd_data     <= '0;
        end else begin
            o_cmd_error <= 1'b0;
            case (state)
                S_IDLE: if (i_cmd_valid) begin
                    if (cmd_ok) begin
                        qbit      <= i_cmd_qbit_num;
                        ins_num   <= i_cmd_ins_num;
                        init_idx  <= i_cmd_init_idx & ({IW{1'b1}} >> shamt);
                        last_row  <= {STATE_ADDR_WIDTH{1'b1}} >> shamt;
                        readback  <= i_cmd_readback;
                        limit     <= i_timeout_limit;
                        ctx_addr  <= '0;
                        row       <= '0;
                        o_timeout <= 1'b0;
                        state     <= i_cmd_ins_num == '0 ? S_INIT : S_LOAD;
                    end else begin
                        o_cmd_error <= 1'b1;
                    end
                end
                S_LOAD: if (i_ctx_valid) begin
                    ctx_addr <= ctx_addr + CA_ONE;
                    if (ctx_addr == ins_num - CA_ONE) state <= S_INIT;
                end
                S_INIT: begin
                    row <= row == last_row ? '0 : row + RA_ONE;
                    if (row == last_row) state <= S_START;
                end
                S_START: begin
                    // Counter value 1 lands in the first RUN cycle, so it equals
                    // the distance from the start cycle.
                    cyc           <= CY_ONE;
                    o_exec_cycles <= '0;
                    state         <= S_RUN;
                end
                S_RUN: begin
                    if (i_qea_complete) begin
                        o_exec_cycles <= cyc;
                        state         <= readback ? S_RB_ISSUE : S_DONE;
                    end else if (limit != '0 && cyc == CYC_WIDTH'(limit)) begin
                        o_exec_cycles <= cyc;
                        o_timeout     <= 1'b1;
                        state         <= S_DONE;
                    end else if (~&cyc) begin
                        cyc <= cyc + CY_ONE;
                    end
                end
                S_RB_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_RB_WAIT;
                end
                S_RB_WAIT: begin
                    if (wait_cnt == 32'(RD_LATENCY - 1)) begin
                        o_rd_data <= i_qea_state_dout;
                        state     <= S_RB_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RB_HOLD: if (i_rd_ready) begin
                    row   <= row + RA_ONE;
                    state <= row == last_row ? S_DONE : S_RB_ISSUE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_cmd_ready    = state == S_IDLE;
        o_busy         = state != S_IDLE && state != S_DONE;
        o_done         = state == S_DONE;
        o_qea_start    = state == S_START;
        o_qea_qbit_num = qbit;
        o_ctx_ready    = state == S_LOAD;
        o_ctx_en       = o_ctx_ready && i_ctx_valid;
        o_ctx_wea      = o_ctx_en;
        o_ctx_addr     = o_ctx_en ? ctx_addr : '0;
        o_ctx_data     = o_ctx_en ? i_ctx_data : '0;
        o_state_ena    = state == S_INIT || state == S_RB_ISSUE;
        o_state_wea    = state == S_INIT;
        o_state_addra  = o_state_ena ? row : '0;
        o_state_dina   = '0;
        // Lane 0 sits in the most significant amplitude slot of the row.
        for (int p = 0; p < PE_NUM; p++)
            if (o_state_wea && row == init_idx[IW-1:PE_NUM_WIDTH] &&
                init_idx[PE_NUM_WIDTH-1:0] == PE_NUM_WIDTH'(p))
                o_state_dina[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] = AMP_ONE;
        o_rd_valid     = state == S_RB_HOLD;
        o_rd_last      = o_rd_valid && row == last_row;
    end
endmodule

// File: tb/tb_qea_run_sequencer.sv
// tb_qea_run_sequencer: directed self-checking bench for qea_run_sequencer with
// a one-cycle-latency state RAM model and a bench-side "core" that rewrites
// the state RAM with a known per-row pattern on start.
module tb_qea_run_sequencer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_qbit = '0;
    logic [15:0]  cmd_ins = '0;
    logic [17:0]  cmd_idx = '0;
    logic         cmd_rb = 1'b0;
    logic [31:0]  tmo = '0;
    logic         ctx_valid = 1'b0;
    logic         ctx_ready;
    logic [63:0]  ctx_data = '0;
    logic         qea_start;
    logic [5:0]   qea_qbit;
    logic         ctx_en, ctx_wea;
    logic [15:0]  ctx_addr;
    logic [63:0]  ctx_dout;
    logic         st_ena, st_wea;
    logic [15:0]  st_addr;
    logic [255:0] st_dina;
    logic         complete = 1'b0;
    logic [255:0] st_dout = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b1;
    logic [255:0] rd_data;
    logic         rd_last;
    logic         busy, done, timeout, cmd_error;
    logic [47:0]  exec_cycles;

    qea_run_sequencer dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_qbit_num(cmd_qbit), .i_cmd_ins_num(cmd_ins),
        .i_cmd_init_idx(cmd_idx), .i_cmd_readback(cmd_rb),
        .i_timeout_limit(tmo),
        .i_ctx_valid(ctx_valid), .o_ctx_ready(ctx_ready), .i_ctx_data(ctx_data),
        .o_qea_start(qea_start), .o_qea_qbit_num(qea_qbit),
        .o_ctx_en(ctx_en), .o_ctx_wea(ctx_wea), .o_ctx_addr(ctx_addr), .o_ctx_data(ctx_dout),
        .o_state_ena(st_ena), .o_state_wea(st_wea), .o_state_addra(st_addr), .o_state_dina(st_dina),
        .i_qea_complete(complete), .i_qea_state_dout(st_dout),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_busy(busy), .o_done(done), .o_timeout(timeout), .o_cmd_error(cmd_error),
        .o_exec_cycles(exec_cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int exp_row = 0, exp_lane = 0, exp_rows = 1;
    logic rdy_toggle = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [255:0] rb_pat(input int r);
        return {8{32'(r) ^ 32'h5A5A0000}};
    endfunction

    function automatic logic [63:0] cw(input int i);
        return {32'hC7C70000 + 32'(i), ~32'(i)};
    endfunction

    function automatic logic [255:0] exp_dina(input int r);
        logic [255:0] one;
        one = {64'h40000000_00000000, 192'b0};
        return r == exp_row ? one >> (exp_lane * 64) : '0;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // State RAM model; a start pulse stands in for the core rewriting every row.
    logic [255:0] mem [0:1023];
    always @(posedge clk) begin
        if (qea_start) begin
            for (int r = 0; r < 1024; r++) mem[r] <= rb_pat(r);
        end else if (st_ena) begin
            if (st_wea) mem[st_addr[9:0]] <= st_dina;
            st_dout <= mem[st_addr[9:0]];
        end
    end

    // Per-command activity monitor, cleared on every command handshake.
    int m_ctx, m_bad_ctx, m_swr, m_bad_swr, m_srd, m_start, m_done;
    int m_rb, m_bad_rb, m_last, m_stall, m_bad_stall;
    logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [255:0] p_data = '0;
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            m_ctx <= 0; m_bad_ctx <= 0; m_swr <= 0; m_bad_swr <= 0; m_srd <= 0;
            m_start <= 0; m_done <= 0; m_rb <= 0; m_bad_rb <= 0; m_last <= 0;
            m_stall <= 0; m_bad_stall <= 0;
        end else begin
            if (ctx_en) begin
                m_ctx <= m_ctx + 1;
                if (!ctx_valid || !ctx_wea || ctx_addr != 16'(m_ctx) || ctx_dout != cw(m_ctx))
                    m_bad_ctx <= m_bad_ctx + 1;
            end
            if (st_ena && st_wea) begin
                m_swr <= m_swr + 1;
                if (st_addr != 16'(m_swr) || st_dina != exp_dina(m_swr)) m_bad_swr <= m_bad_swr + 1;
            end
            if (st_ena && !st_wea) m_srd <= m_srd + 1;
            if (qea_start) m_start <= m_start + 1;
            if (done) m_done <= m_done + 1;
            if (rd_valid && !rd_ready) m_stall <= m_stall + 1;
            if (rd_valid && p_valid && !p_ready && (rd_data != p_data || rd_last != p_last))
                m_bad_stall <= m_bad_stall + 1;
            if (rd_valid && rd_ready) begin
                m_rb <= m_rb + 1;
                if (rd_last) m_last <= m_last + 1;
                if (rd_data != rb_pat(m_rb) || rd_last != (m_rb == exp_rows - 1))
                    m_bad_rb <= m_bad_rb + 1;
            end
        end
        p_valid <= rd_valid;
        p_ready <= rd_ready;
        p_data  <= rd_data;
        p_last  <= rd_last;
    end

    initial forever begin
        @(posedge clk);
        #1 rd_ready = rdy_toggle ? ~rd_ready : 1'b1;
    end

    task automatic send_cmd(input logic [5:0] q, input logic [15:0] ins,
                            input logic [17:0] idx, input logic rb, input logic [31:0] lim);
        @(posedge clk);
        #1;
        cmd_qbit = q; cmd_ins = ins; cmd_idx = idx; cmd_rb = rb; tmo = lim;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic feed(input int ins, input logic gaps);
        int i = 0;
        int t = 0;
        while (i < ins && t < 5000) begin
            @(posedge clk);
            #1;
            ctx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ctx_data = cw(i);
            @(negedge clk);
            if (ctx_valid && ctx_ready) i++;
            t++;
        end
        @(posedge clk);
        #1 ctx_valid = 1'b0;
        chk("ctx_feed_bound", 32'(i), 32'(ins));
    endtask

    task automatic do_cmd(input logic [5:0] q, input int ins, input logic [17:0] idx,
                          input logic rb, input int lim, input logic gaps, input int delay,
                          input int erow, input int elane, input int rows,
                          input int xexec, input logic xto, input int xrb);
        int t, start_c, done_c;
        exp_row = erow; exp_lane = elane; exp_rows = rows;
        send_cmd(q, 16'(ins), idx, rb, 32'(lim));
        chk("busy_after_accept", busy, 1);
        chk("timeout_clr", timeout, 0);
        chk("qbit_latch", qea_qbit, q);
        feed(ins, gaps);
        t = 0;
        @(negedge clk);
        while (!qea_start && t < 3000) begin @(negedge clk); t++; end
        chk("start_seen", qea_start, 1);
        start_c = cycle;
        if (delay >= 0) begin
            repeat (delay) @(posedge clk);
            #1 complete = 1'b1;
        end
        t = 0;
        while (!done && t < 10000) begin @(negedge clk); t++; end
        done_c = cycle;
        chk("done_seen", done, 1);
        chk("busy_in_done", busy, 0);
        @(negedge clk);
        chk("ready_after_done", cmd_ready, 1);
        chk("done_single", done, 0);
        if (xexec >= 0) chk("exec_cycles", exec_cycles, 48'(xexec));
        if (xto) chk("timeout_latency", 32'(done_c - start_c), 32'(lim + 1));
        chk("timeout_flag", timeout, xto);
        chk("ctx_writes", 32'(m_ctx), 32'(ins));
        chk("ctx_bad", 32'(m_bad_ctx), 0);
        chk("state_writes", 32'(m_swr), 32'(rows));
        chk("state_bad", 32'(m_bad_swr), 0);
        chk("start_pulses", 32'(m_start), 1);
        chk("done_pulses", 32'(m_done), 1);
        chk("rb_reads", 32'(m_srd), 32'(xrb));
        chk("rb_rows", 32'(m_rb), 32'(xrb));
        chk("rb_bad", 32'(m_bad_rb), 0);
        chk("rb_last", 32'(m_last), xrb > 0 ? 1 : 0);
        chk("rb_stall_stable", 32'(m_bad_stall), 0);
        @(posedge clk);
        #1 complete = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctrl"}, {qea_start, ctx_en, ctx_wea, ctx_ready, st_ena, st_wea, rd_valid,
                             rd_last, busy, done, timeout, cmd_error}, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_dina"}, st_dina, 0);
        chk({tag, "_misc"}, {ctx_addr, ctx_dout, st_addr, qea_qbit, exec_cycles}, 0);
    endtask

    initial begin
        int t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Large run: dense context stream, 512 rows, stalled readback.
        rdy_toggle = 1'b1;
        do_cmd(6'd11, 163, 18'd0, 1'b1, 0, 1'b0, 100, 0, 0, 512, 100, 1'b0, 512);
        chk("rb_stalls_seen", 32'(m_stall > 0), 1);
        rdy_toggle = 1'b0;

        // Gappy context stream, no readback.
        do_cmd(6'd4, 20, 18'd6, 1'b0, 0, 1'b1, 30, 1, 2, 4, 30, 1'b0, 0);

        // Timeout with readback requested: no reads may follow.
        do_cmd(6'd4, 3, 18'd0, 1'b1, 50, 1'b0, -1, 0, 0, 4, -1, 1'b1, 0);

        // Smallest legal size, no context words, single readback row.
        do_cmd(6'd2, 0, 18'd3, 1'b1, 0, 1'b0, 5, 0, 3, 1, 5, 1'b0, 1);

        // Rejects on both sides of the legal qubit range.
        send_cmd(6'd1, 16'd4, 18'd0, 1'b1, 32'd0);
        chk("rej_lo_err", cmd_error, 1);
        chk("rej_lo_busy", busy, 0);
        chk("rej_lo_ready", cmd_ready, 1);
        @(posedge clk);
        #1 chk("rej_lo_err_pulse", cmd_error, 0);
        send_cmd(6'd19, 16'd4, 18'd0, 1'b1, 32'd0);
        chk("rej_hi_err", cmd_error, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("rej_busy", busy, 0);
        chk("rej_ram", 32'(m_swr + m_srd + m_ctx + m_start), 0);

        // Reset in the middle of state initialisation.
        exp_row = 0; exp_lane = 0; exp_rows = 512;
        send_cmd(6'd11, 16'd2, 18'd0, 1'b1, 32'd0);
        feed(2, 1'b0);
        t = 0;
        while (!(st_wea && st_addr == 16'd37) && t < 2000) begin @(posedge clk); #1; t++; end
        chk("row37_seen", st_addr, 37);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("midrst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("midrst_writes", 32'(m_swr), 38);

        // Following command with init index bits above qbit_num that must be masked.
        do_cmd(6'd5, 4, 18'h3FC05, 1'b1, 0, 1'b0, 10, 1, 1, 8, 10, 1'b0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/qea_run_sequencer.md
Name: qea_run_sequencer

Overview:
Hardware host sequencer for the QEA core, for a generalised PE count and qubit count. It accepts one command, then streams gate-context words into the QEA context RAM and initialises the state RAM to a selectable computational basis state. It then pulses start, waits for completion with a timeout, measures the execution cycles, and optionally streams the final state vector out with valid/ready backpressure.

Parameters:
PE_NUM, 4, amplitudes per state-RAM row (power of 2)
PE_NUM_WIDTH, 2, log2(PE_NUM)
DATA_WIDTH, 32, real/imag component width
STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude {re,im}
STATE_ADDR_WIDTH, 16, state RAM row address width
GATE_CONTEXT_DATA_WIDTH, 64, context word width
GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
MAX_QBIT_WIDTH, 6, qubit-count field width
NUM_FRAC_BIT, 30, fixed-point fraction bits (1.0 = 1<<NUM_FRAC_BIT)
RD_LATENCY, 1, QEA state RAM read latency in cycles (>=1)
CYC_WIDTH, 48, execution cycle counter width

Ports:
clk  in  1  clock
rst  in  1  reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  high only in IDLE
i_cmd_qbit_num  in  MAX_QBIT_WIDTH  qubit count
i_cmd_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context words to load
i_cmd_init_idx  in  STATE_ADDR_WIDTH+PE_NUM_WIDTH  initial basis-state index
i_cmd_readback  in  1  stream final state after run
i_timeout_limit  in  32  max RUN cycles; 0 = no timeout
i_ctx_valid / o_ctx_ready  in/out  1/1  context word stream handshake
i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
o_qea_start  out  1  one-cycle start pulse
o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count
o_ctx_en, o_ctx_wea  out  1, 1  context RAM enable/write
o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM address
o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context RAM data
o_state_ena, o_state_wea  out  1, 1  state RAM enable/write
o_state_addra  out  STATE_ADDR_WIDTH  state row address
o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state row write data
i_qea_complete  in  1  QEA run complete level
i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state row read data
o_rd_valid / i_rd_ready  out/in  1/1  readback stream handshake
o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  readback row
o_rd_last  out  1  final readback row
o_busy  out  1  command in progress
o_done  out  1  one-cycle pulse when returning to IDLE
o_timeout  out  1  last run timed out; cleared on next command accept
o_cmd_error  out  1  one-cycle pulse, command rejected
o_exec_cycles  out  CYC_WIDTH  cycles of last run

Behaviour:
Reset:
- One clock domain. Reset is synchronous and active-high on rst; clock is clk.
- Reset forces IDLE and sets every output to 0, except o_cmd_ready, which is 1.
- Reset mid-operation aborts on the next edge with no further RAM writes.

States: IDLE -> LOAD_CTX -> INIT_STATE -> START -> RUN -> (RB_ISSUE -> RB_WAIT -> RB_HOLD)* -> DONE -> IDLE.

Command accept and checks:
- Accept on i_cmd_valid & o_cmd_ready. Latch all command fields. o_busy is set the next cycle.
- Reject the command if qbit_num < PE_NUM_WIDTH or qbit_num > STATE_ADDR_WIDTH+PE_NUM_WIDTH.
- On reject: pulse o_cmd_error, stay in IDLE, no RAM activity, o_busy stays 0.

LOAD_CTX:
- o_ctx_ready = 1.
- Each handshake writes one word: o_ctx_en = o_ctx_wea = 1 for that cycle, o_ctx_addr = 0, 1, 2, ..., o_ctx_data = word.
- Stream gaps produce no write.
- Leave after ins_num words. ins_num = 0 skips this state.

INIT_STATE:
- ROWS = 2^(qbit_num-PE_NUM_WIDTH). Write rows 0..ROWS-1, one per cycle, o_state_ena = o_state_wea = 1.
- Lane p occupies o_state_dina[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH].
- init_idx is masked to qbit_num bits.
- Row init_idx>>PE_NUM_WIDTH, lane init_idx[PE_NUM_WIDTH-1:0] gets re = 1<<NUM_FRAC_BIT, im = 0. All other amplitudes are 0.

START:
- o_qea_start = 1 for exactly one cycle. o_exec_cycles and the timeout counter clear.

RUN:
- The counter increments each cycle.
- When i_qea_complete is sampled high, o_exec_cycles = (that cycle's index) - (start cycle index).
- If i_timeout_limit != 0 and the counter reaches the limit: set o_timeout, go to DONE, skip readback.
- After completion, go to readback if the readback flag is set, else DONE.

Readback:
- RB_ISSUE: o_state_ena = 1, o_state_wea = 0, drive the row address.
- RB_WAIT: hold for RD_LATENCY cycles, then capture i_qea_state_dout.
- RB_HOLD: o_rd_valid = 1. o_rd_data and o_rd_last stay stable until i_rd_ready. o_rd_last = 1 on row ROWS-1.
- Rows are emitted in order 0..ROWS-1.

DONE:
- Pulse o_done, drop o_busy, go to IDLE.

Counters:
- Address counters do not wrap within a command. The ctx address is bounded by ins_num.
- The exec counter saturates at all-ones.

Test Plan:
1. PE_NUM=4, qbit=11, ins_num=163, init_idx=0, readback=1. Context words arrive every cycle -> ctx writes to addresses 0..162 with matching data. 512 state writes. Row 0 dina = {64'h40000000_00000000, 3×64'h0}, all others 0. One start pulse.
2. qbit=4, init_idx=6. A second variant sends context words with random valid gaps -> 4 row writes, only row 1 lane 2 = 64'h40000000_00000000. No ctx write on any gap cycle; addresses stay contiguous.
3. Model raises complete 100 cycles after start -> o_exec_cycles = 100, o_timeout = 0, o_done pulse once.
4. Readback with qbit=11 and i_rd_ready toggling 1/0 -> 512 rows in order. Data stable while stalled. o_rd_last only on row 511. wea never asserted during readback.
5. i_timeout_limit=50, complete never rises -> o_timeout = 1 after 50 RUN cycles. No readback reads. o_done pulse, o_cmd_ready = 1.
6. Cases:
   - qbit=1 -> o_cmd_error pulse, no RAM enables.
   - rst during INIT_STATE row 37 -> all outputs 0 next cycle, o_cmd_ready = 1.
   - A following valid command completes correctly.
